// File: rtl/spi_core_if.sv
// rtl/spi_core_if.sv - MMIO slot bus between the FPro controller and a slot core
interface spi_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/spi_core.sv
// rtl/spi_core.sv - single-byte SPI master slot core with CPOL/CPHA and divisor
module spi_core #(
  parameter int S = 1
) (
  input  logic         clk,
  input  logic         reset,
  spi_core_if.slave    bus,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n
);

  typedef enum logic [1:0] {IDLE, CPHA_DLY, P0, P1} state_t;

  state_t       state_reg, state_next;
  logic [15:0]  c_reg, c_next;
  logic [2:0]   n_reg, n_next;
  logic [7:0]   tx_reg, tx_next;
  logic [7:0]   rx_reg, rx_next;
  logic [7:0]   rxd_reg, rxd_next;
  logic [15:0]  dvsr_reg;
  logic         cpol_reg, cpha_reg;
  logic [S-1:0] ss_n_reg;
  logic         sclk_reg, sclk_next;
  logic         ready;
  logic         wr_en, start, cfg_wr, ss_wr, half_done;
  logic         unused_ok;

  assign wr_en     = bus.cs & bus.write;
  assign start     = wr_en && (bus.addr == 5'd2) && (state_reg == IDLE);
  assign cfg_wr    = wr_en && (bus.addr == 5'd3) && (state_reg == IDLE);
  assign ss_wr     = wr_en && (bus.addr == 5'd1);
  // Compare rather than count down so dvsr=0xFFFF gives a full 65536-cycle half-period
  assign half_done = (c_reg == dvsr_reg);
  assign unused_ok = &{1'b0, bus.read, bus.wr_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = cpha_reg ? CPHA_DLY : P0;
      CPHA_DLY: if (half_done) state_next = P0;
      P0:       if (half_done) state_next = P1;
      P1:       if (half_done) state_next = (n_reg == 3'd7) ? IDLE : P0;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_reg == IDLE);
    c_next   = (state_next != state_reg || state_reg == IDLE) ? 16'd0 : c_reg + 16'd1;
    n_next   = n_reg;
    tx_next  = tx_reg;
    rx_next  = rx_reg;
    rxd_next = rxd_reg;
    case (state_reg)
      IDLE: if (start) begin
        tx_next = bus.wr_data[7:0];
        n_next  = 3'd0;
      end
      P0: if (half_done) rx_next = {rx_reg[6:0], spi_miso};
      P1: if (half_done) begin
        if (n_reg == 3'd7) begin
          rxd_next = rx_reg;
        end else begin
          tx_next = {tx_reg[6:0], 1'b0};
          n_next  = n_reg + 3'd1;
        end
      end
      default: ;
    endcase
    // Computed from the upcoming state so the registered clock lines up with it
    sclk_next = cpol_reg ^ (cpha_reg ? (state_next == P0) : (state_next == P1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_reg    <= '0;
      n_reg    <= '0;
      tx_reg   <= '0;
      rx_reg   <= '0;
      rxd_reg  <= '0;
      dvsr_reg <= '0;
      cpol_reg <= 1'b0;
      cpha_reg <= 1'b0;
      ss_n_reg <= '1;
      sclk_reg <= 1'b0;
    end else begin
      c_reg    <= c_next;
      n_reg    <= n_next;
      tx_reg   <= tx_next;
      rx_reg   <= rx_next;
      rxd_reg  <= rxd_next;
      sclk_reg <= sclk_next;
      if (cfg_wr) begin
        dvsr_reg <= bus.wr_data[15:0];
        cpol_reg <= bus.wr_data[16];
        cpha_reg <= bus.wr_data[17];
      end
      if (ss_wr) ss_n_reg <= bus.wr_data[S-1:0];
    end
  end

  assign spi_sclk    = sclk_reg;
  assign spi_mosi    = tx_reg[7];
  assign spi_ss_n    = ss_n_reg;
  assign bus.rd_data = (bus.cs && bus.addr == 5'd0) ? {23'b0, ready, rxd_reg} : 32'd0;

endmodule

// File: tb/tb_spi_core.sv
// tb/tb_spi_core.sv - directed self-checking bench for spi_core
module tb_spi_core;
  localparam int S = 4;

  logic         clk;
  logic         reset;
  logic         spi_sclk, spi_mosi, spi_miso;
  logic [S-1:0] spi_ss_n;
  logic         miso_one;
  int           total = 0;
  int           bad   = 0;
  int           lo, rises;
  logic [7:0]   pat;

  spi_core_if bus();

  spi_core #(.S(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  assign spi_miso = miso_one ? 1'b1 : spi_mosi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cs      = 1'b1;
    bus.read    = 1'b1;
    bus.write   = 1'b0;
    bus.addr    = 5'd0;
    bus.wr_data = 32'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic sel);
    @(negedge clk);
    bus.cs      = sel;
    bus.read    = 1'b0;
    bus.write   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    @(negedge clk);
    bus_idle();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Starts a transfer and watches it until ready returns; optional mid-transfer writes
  task automatic run_xfer(input logic [7:0] tx, input bit inject,
                          output int lo_n, output int rise_n, output logic [7:0] p);
    logic prev;
    bit   done;
    int   cyc;
    wr(5'd2, {24'd0, tx}, 1'b1);
    prev = spi_sclk;
    lo_n = 0; rise_n = 0; p = 8'd0; done = 1'b0; cyc = 0;
    while (cyc < 2000) begin
      if (bus.addr == 5'd0 && bus.rd_data[8]) begin
        done = 1'b1;
        break;
      end
      lo_n++;
      if (!prev && spi_sclk) begin
        rise_n++;
        p = {p[6:0], spi_mosi};
      end
      prev = spi_sclk;
      bus_idle();
      if (inject && cyc == 5) begin
        bus.write = 1'b1; bus.addr = 5'd2; bus.wr_data = 32'h11;
      end else if (inject && cyc == 7) begin
        bus.write = 1'b1; bus.addr = 5'd3; bus.wr_data = 32'h5;
      end else if (inject && cyc == 9) begin
        bus.write = 1'b1; bus.addr = 5'd1; bus.wr_data = 32'h3;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    bus_idle();
    #1;
    check("xfer_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    bus_idle();
    miso_one = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_rd", bus.rd_data, 32'h100);
    check("rst_ss", {28'd0, spi_ss_n}, 32'hF);
    check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd0);

    // Mode 0, dvsr=1, loopback
    wr(5'd3, 32'h1, 1'b1);
    wr(5'd1, 32'h0, 1'b1);
    check("ss_wr", {28'd0, spi_ss_n}, 32'h0);
    run_xfer(8'hA5, 1'b0, lo, rises, pat);
    check("m0_len", lo, 32);
    check("m0_rises", rises, 8);
    check("m0_mosi", {24'd0, pat}, 32'hA5);
    check("m0_rd", bus.rd_data, 32'h1A5);

    // Mode 3, dvsr=0, miso tied high
    miso_one = 1'b1;
    wr(5'd3, 32'h30000, 1'b1);
    idle(2);
    check("m3_idle_sclk", {31'd0, spi_sclk}, 32'd1);
    run_xfer(8'h3C, 1'b0, lo, rises, pat);
    check("m3_len", lo, 17);
    check("m3_rises", rises, 8);
    check("m3_rd", bus.rd_data, 32'h1FF);
    idle(2);
    check("m3_end_sclk", {31'd0, spi_sclk}, 32'd1);

    // Busy-time writes: start and config ignored, slave select accepted
    miso_one = 1'b0;
    wr(5'd3, 32'h1, 1'b1);
    idle(2);
    check("m0_idle_sclk", {31'd0, spi_sclk}, 32'd0);
    run_xfer(8'hA5, 1'b1, lo, rises, pat);
    check("busy_len", lo, 32);
    check("busy_mosi", {24'd0, pat}, 32'hA5);
    check("busy_rd", bus.rd_data, 32'h1A5);
    check("busy_ss", {28'd0, spi_ss_n}, 32'h3);
    wr(5'd1, 32'h0, 1'b1);

    // Reset around bit 4 of a transfer
    wr(5'd2, 32'h5A, 1'b1);
    idle(18);
    check("mid_rd_hold", bus.rd_data, 32'h0A5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    check("abort_ss", {28'd0, spi_ss_n}, 32'hF);
    check("abort_rd", bus.rd_data, 32'h100);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    check("post_rst_rd", bus.rd_data, 32'h100);
    wr(5'd1, 32'h0, 1'b1);
    run_xfer(8'h5A, 1'b0, lo, rises, pat);
    check("post_len", lo, 16);
    check("post_rises", rises, 8);
    check("post_mosi", {24'd0, pat}, 32'h5A);
    check("post_rd", bus.rd_data, 32'h15A);

    // Writes with cs low must not land
    wr(5'd1, 32'hF, 1'b0);
    wr(5'd3, 32'h30007, 1'b0);
    wr(5'd2, 32'hFF, 1'b0);
    idle(3);
    check("nocs_ss", {28'd0, spi_ss_n}, 32'h0);
    check("nocs_sclk", {31'd0, spi_sclk}, 32'd0);
    check("nocs_rd", bus.rd_data, 32'h15A);
    bus.cs = 1'b0;
    #1;
    check("nocs_rd_zero", bus.rd_data, 32'h0);
    bus.cs   = 1'b1;
    bus.addr = 5'd1;
    #1;
    check("addr1_rd_zero", bus.rd_data, 32'h0);
    bus_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_core.md
Name: spi_core

Overview:
- FPro slot core implementing a single-byte SPI master.
- Sits directly downstream of the MMIO controller in one of its 64 slots and consumes that slot's cs/read/write/reg-address/write-data signals.
- Returns read data on the slot's rd_data line.
- Supports programmable SCLK divisor, CPOL/CPHA modes and software-controlled slave selects.

Parameters:
S, 1, number of slave-select outputs (1..32)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cs  in  1  slot select from MMIO controller
read  in  1  read strobe (broadcast)
write  in  1  write strobe (broadcast)
addr  in  5  register address within slot
wr_data  in  32  write data
rd_data  out  32  read data (combinational mux of registers)
spi_sclk  out  1  SPI serial clock
spi_mosi  out  1  master-out data, MSB first
spi_miso  in  1  master-in data
spi_ss_n  out  S  active-low slave selects

Behaviour:
- One clock domain; reset is asynchronous, active-high; all flops clear on reset assertion.
- Register write occurs on a clk edge with cs=1 and write=1. The read strobe has no side effects.
- Register map (addr):
  - 0 read: {23'b0, ready, rx_data[7:0]}
  - 1 write: ss_n_reg <= wr_data[S-1:0]
  - 2 write: start a transfer of tx byte wr_data[7:0]
  - 3 write: dvsr <= wr_data[15:0], cpol <= wr_data[16], cpha <= wr_data[17]
- rd_data is 0 for addr≠0 and when cs=0.
- Reset values: dvsr=0, cpol=0, cpha=0, ss_n_reg=all ones, rx_data=0, FSM=IDLE, ready=1, spi_mosi=0, spi_sclk=0.
- spi_ss_n = ss_n_reg at all times; it is never auto-toggled by the FSM. Writes to addr 1 are accepted even while busy.
- FSM states: IDLE, CPHA_DLY, P0, P1. Half-period = dvsr+1 clk cycles, counted by a 16-bit counter cleared on every state change.
  - IDLE: ready=1. A start write loads the shift register with the tx byte and clears the bit counter. It then goes to CPHA_DLY if cpha=1, else to P0.
  - CPHA_DLY: lasts one half-period, then goes to P0.
  - P0: at the end of the half-period, shift spi_miso into the rx shift register LSB, then go to P1.
  - P1: at the end of the half-period:
    - if bit counter=7: copy the rx shift register to rx_data and go to IDLE;
    - else: shift the tx register left, increment the bit counter and go to P0.
- spi_mosi = tx shift register bit 7, valid from the cycle after the start write.
- spi_sclk is registered and equals cpol XOR (cpha ? state==P0 : state==P1). It idles at cpol.
- Transfer length, from the start write to ready=1:
  - cpha=0: 16*(dvsr+1) cycles
  - cpha=1: 17*(dvsr+1) cycles
- ready drops in the cycle after an accepted start write.
- Start writes and addr-3 writes while ready=0 are ignored, with no state change.
- rx_data holds the previous byte until the current transfer completes; it is never partially updated.
- Reset asserted mid-transfer aborts immediately: ss_n goes all ones, sclk=0, and the partial rx byte is discarded.
- dvsr=0xFFFF is legal: half-period is 65536 cycles and the counter must not overflow early.

Test Plan:
- Reset, read addr 0 -> rd_data=0x00000100; spi_ss_n all ones; spi_sclk=0; spi_mosi=0.
- Write addr3=0x00000001, addr1=0x0, addr2=0xA5; loopback miso=mosi -> 8 rising sclk edges, mosi pattern 1,0,1,0,0,1,0,1; ready=0 for exactly 32 cycles; addr0 then reads 0x1A5.
- Mode 3 (addr3=0x00030000), tx 0x3C, miso tied 1 -> sclk idles 1; ready=0 for 17 cycles; rx_data=0xFF.
- Second start write (0x11) mid-transfer of 0xA5 -> ignored; the transfer completes with 0xA5 bits; an addr3 write mid-transfer leaves dvsr unchanged.
- Assert reset at bit 4 of a transfer -> next cycle ready=1, ss_n all ones, rx_data=0; a subsequent transfer behaves normally.
- Writes with cs=0 to addrs 1–3 -> no register, FSM or output change; rd_data=0 with cs=0.
